// File: rtl/avalon_timer_pkg.sv
// Register map, bit positions and defaults shared by the interval timer and its bench.
package avalon_timer_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int DEFAULT_RESET_PERIOD = 24999;

endpackage

// File: rtl/timer_down_counter.sv
// Down-counter that reloads at zero while running; an explicit load overrides counting.
// Latency: load/decrement visible one clock after the request; no backpressure.
module timer_down_counter #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign zero  = (count_q == '0);
  assign count = count_q;

  // Reload at zero instead of wrapping, so the tick length is load_value+1 clocks.
  always_comb begin
    count_d = count_q;
    if (load || (run && zero)) begin
      count_d = load_value;
    end else if (run) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/avalon_interval_timer_v2.sv
// Avalon-MM interval timer: period/snapshot registers, one-shot or continuous, level irq.
// Latency: reads 1 clock, writes act on the sampling edge; no wait states, no backpressure.
module avalon_interval_timer_v2
  import avalon_timer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int RESET_PERIOD  = DEFAULT_RESET_PERIOD,
  parameter bit ALWAYS_RUN    = 1'b0,
  parameter bit RESET_CONT    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam logic [COUNTER_WIDTH-1:0] RESET_PERIOD_W = COUNTER_WIDTH'(RESET_PERIOD);
  localparam logic                     RESET_CONT_W   = ALWAYS_RUN ? 1'b1 : RESET_CONT;

  logic [COUNTER_WIDTH-1:0] period_q, period_d;
  logic [COUNTER_WIDTH-1:0] snap_q, snap_d;
  logic                     to_q, to_d;
  logic                     ito_q, ito_d;
  logic                     cont_q, cont_d;
  logic                     run_q, run_d;
  logic [15:0]              readdata_q, readdata_d;

  logic [COUNTER_WIDTH-1:0] count;
  logic                     zero;
  logic                     timeout;
  logic                     wr_en;
  logic                     period_wr;
  logic [31:0]              period_full;
  logic [31:0]              period_new;
  logic [31:0]              snap_full;

  assign wr_en       = chipselect & ~write_n;
  assign timeout     = run_q & zero;
  assign period_full = 32'(period_q);
  assign snap_full   = 32'(snap_q);

  always_comb begin
    period_new = period_full;
    period_wr  = 1'b0;
    snap_d     = snap_q;
    to_d       = to_q;
    ito_d      = ito_q;
    cont_d     = cont_q;
    run_d      = run_q;

    if (timeout && !cont_q) begin
      run_d = 1'b0;
    end

    if (wr_en) begin
      case (address)
        ADDR_STATUS: to_d = 1'b0;
        ADDR_CONTROL: begin
          ito_d = writedata[CTRL_ITO];
          if (!ALWAYS_RUN) begin
            cont_d = writedata[CTRL_CONT];
            if (writedata[CTRL_START]) run_d = 1'b1;
            if (writedata[CTRL_STOP])  run_d = 1'b0;
          end
        end
        ADDR_PERIODL: begin
          period_new[15:0] = writedata;
          period_wr        = 1'b1;
        end
        ADDR_PERIODH: begin
          period_new[31:16] = writedata;
          period_wr         = 1'b1;
        end
        ADDR_SNAPL, ADDR_SNAPH: snap_d = count;
        default: ;
      endcase
    end

    // A timeout on the same clock as a STATUS clear must not be lost.
    if (timeout) begin
      to_d = 1'b1;
    end

    period_d = period_new[COUNTER_WIDTH-1:0];
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS: begin
        readdata_d[STATUS_TO]  = to_q;
        readdata_d[STATUS_RUN] = run_q;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_ITO]  = ito_q;
        readdata_d[CTRL_CONT] = cont_q;
      end
      ADDR_PERIODL: readdata_d = period_full[15:0];
      ADDR_PERIODH: readdata_d = period_full[31:16];
      ADDR_SNAPL:   readdata_d = snap_full[15:0];
      ADDR_SNAPH:   readdata_d = snap_full[31:16];
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q   <= RESET_PERIOD_W;
      snap_q     <= '0;
      to_q       <= 1'b0;
      ito_q      <= 1'b0;
      cont_q     <= RESET_CONT_W;
      run_q      <= ALWAYS_RUN;
      readdata_q <= '0;
    end else begin
      period_q   <= period_d;
      snap_q     <= snap_d;
      to_q       <= to_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      run_q      <= run_d;
      readdata_q <= readdata_d;
    end
  end

  // The counter loads the freshly written period on the write edge itself.
  timer_down_counter #(
    .WIDTH       (COUNTER_WIDTH),
    .RESET_VALUE (RESET_PERIOD_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .run        (run_q),
    .load       (period_wr),
    .load_value (period_d),
    .count      (count),
    .zero       (zero)
  );

  assign readdata = readdata_q;
  assign irq      = to_q & ito_q;

endmodule

// File: tb/tb_avalon_interval_timer_v2.sv
// Scoreboarded bench: 32-bit and 15-bit timer instances sharing one Avalon bus.
module tb_avalon_interval_timer_v2;
  import avalon_timer_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        cs0, cs1;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata0, readdata1;
  logic        irq0, irq1;

  typedef struct {
    string       name;
    int          src;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [15:0] act;
  int          rd_req;
  int          rd_vld_src;
  int          checks;
  int          failures;

  avalon_interval_timer_v2 #(
    .COUNTER_WIDTH(32), .RESET_PERIOD(24999), .ALWAYS_RUN(1'b0), .RESET_CONT(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs0), .write_n(write_n),
    .writedata(writedata), .readdata(readdata0), .irq(irq0)
  );

  avalon_interval_timer_v2 #(
    .COUNTER_WIDTH(15), .RESET_PERIOD(24999), .ALWAYS_RUN(1'b0), .RESET_CONT(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1), .write_n(write_n),
    .writedata(writedata), .readdata(readdata1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_vld_src <= rd_req;

  // src 0/1 = readdata of dut0/dut1, src 2 = dut0 irq after the edge.
  always @(negedge clk) begin
    if (rd_vld_src >= 0) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        cur = sb_q.pop_front();
        act = (cur.src == 0) ? readdata0 : (cur.src == 1) ? readdata1 : {15'b0, irq0};
        if (act !== cur.exp) begin
          failures++;
          $display("FAIL %s: got 0x%04h expected 0x%04h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic cyc(input logic c0, input logic c1, input logic wr, input logic [2:0] a,
                     input logic [15:0] d, input int src, input logic [15:0] e, input string nm);
    exp_t t;
    @(negedge clk);
    cs0       = c0;
    cs1       = c1;
    write_n   = ~wr;
    address   = a;
    writedata = d;
    rd_req    = src;
    if (src >= 0) begin
      t.name = nm;
      t.src  = src;
      t.exp  = e;
      sb_q.push_back(t);
    end
  endtask

  task automatic wr0(input logic [2:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, 1'b1, a, d, -1, 16'h0, "");
  endtask

  task automatic wr1(input logic [2:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, 1'b1, a, d, -1, 16'h0, "");
  endtask

  task automatic rd0(input logic [2:0] a, input logic [15:0] e, input string nm);
    cyc(1'b1, 1'b0, 1'b0, a, 16'h0, 0, e, nm);
  endtask

  task automatic rd1(input logic [2:0] a, input logic [15:0] e, input string nm);
    cyc(1'b0, 1'b1, 1'b0, a, 16'h0, 1, e, nm);
  endtask

  task automatic irqchk(input logic e, input string nm);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 2, {15'b0, e}, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, -1, 16'h0, "");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset  = 1'b1;
    cs0    = 1'b0;
    cs1    = 1'b0;
    rd_req = -1;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs0 = 1'b0; cs1 = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = 16'h0; rd_req = -1; rd_vld_src = -1;
    checks = 0; failures = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rd0(ADDR_STATUS,  16'h0000, "rst_status");
    rd0(ADDR_PERIODL, 16'h61A7, "rst_periodl");
    rd0(ADDR_PERIODH, 16'h0000, "rst_periodh");
    rd0(ADDR_CONTROL, 16'h0002, "rst_control");
    irqchk(1'b0, "rst_irq");
    rd1(ADDR_PERIODL, 16'h61A7, "w15_rst_periodl");

    // Continuous, period 4: timeouts every 5 clocks.
    wr0(ADDR_PERIODL, 16'd4);
    wr0(ADDR_CONTROL, 16'h0007);
    idle(3);
    irqchk(1'b0, "cont_irq_before_to");
    irqchk(1'b1, "cont_irq_rise");
    wr0(ADDR_STATUS, 16'h0000);
    irqchk(1'b0, "cont_irq_cleared");
    irqchk(1'b0, "cont_irq_gap1");
    irqchk(1'b0, "cont_irq_gap2");
    irqchk(1'b1, "cont_second_to");
    rd0(ADDR_STATUS, 16'h0003, "cont_status");

    // One-shot, period 2.
    wr0(ADDR_CONTROL, 16'h0008);
    wr0(ADDR_STATUS,  16'h0000);
    wr0(ADDR_PERIODL, 16'd2);
    wr0(ADDR_CONTROL, 16'h0004);
    rd0(ADDR_STATUS, 16'h0002, "os_running1");
    rd0(ADDR_STATUS, 16'h0002, "os_running2");
    rd0(ADDR_STATUS, 16'h0002, "os_running3");
    rd0(ADDR_STATUS, 16'h0001, "os_to_run_clear");
    wr0(ADDR_SNAPL, 16'h0000);
    rd0(ADDR_SNAPL, 16'h0002, "os_count_held");

    // START+STOP together, then timeout coinciding with a STATUS write.
    wr0(ADDR_STATUS,  16'h0000);
    wr0(ADDR_CONTROL, 16'h000C);
    rd0(ADDR_STATUS, 16'h0000, "start_stop_run0");
    wr0(ADDR_CONTROL, 16'h0006);
    idle(2);
    wr0(ADDR_STATUS, 16'h0000);
    rd0(ADDR_STATUS, 16'h0003, "to_set_wins");
    wr0(ADDR_CONTROL, 16'h0008);

    // Period 0x0001_0000: snapshot across halves, then reload without wrap.
    wr0(ADDR_STATUS,  16'h0000);
    wr0(ADDR_PERIODL, 16'h0000);
    wr0(ADDR_PERIODH, 16'h0001);
    wr0(ADDR_CONTROL, 16'h0006);
    idle(2);
    wr0(ADDR_SNAPL, 16'h0000);
    rd0(ADDR_SNAPL,   16'hFFFE, "snap_low");
    rd0(ADDR_SNAPH,   16'h0000, "snap_high");
    rd0(ADDR_PERIODH, 16'h0001, "periodh_readback");
    idle(65529);
    rd0(ADDR_STATUS, 16'h0002, "big_before_zero");
    rd0(ADDR_STATUS, 16'h0002, "big_at_zero");
    wr0(ADDR_SNAPL, 16'h0000);
    rd0(ADDR_SNAPH,  16'h0001, "reload_snap_high");
    rd0(ADDR_SNAPL,  16'h0000, "reload_snap_low");
    rd0(ADDR_STATUS, 16'h0003, "reload_status");

    // 15-bit instance: bits above the width are dropped.
    wr1(ADDR_PERIODH, 16'hFFFF);
    rd1(ADDR_PERIODH, 16'h0000, "w15_periodh");
    wr1(ADDR_PERIODL, 16'hFFFF);
    rd1(ADDR_PERIODL, 16'h7FFF, "w15_periodl");

    // Period 0 continuous: irq held high.
    wr0(ADDR_CONTROL, 16'h0008);
    wr0(ADDR_STATUS,  16'h0000);
    wr0(ADDR_PERIODH, 16'h0000);
    wr0(ADDR_PERIODL, 16'h0000);
    wr0(ADDR_CONTROL, 16'h0007);
    irqchk(1'b1, "p0_irq");
    wr0(ADDR_STATUS, 16'h0000);
    irqchk(1'b1, "p0_irq_held");
    rd0(ADDR_STATUS, 16'h0003, "p0_status");

    // Reset mid-count.
    pulse_reset();
    rd0(ADDR_STATUS,  16'h0000, "mid_rst_status");
    rd0(ADDR_PERIODL, 16'h61A7, "mid_rst_periodl");
    rd0(ADDR_PERIODH, 16'h0000, "mid_rst_periodh");
    rd0(ADDR_CONTROL, 16'h0002, "mid_rst_control");
    rd0(ADDR_SNAPL,   16'h0000, "mid_rst_snapl");
    irqchk(1'b0, "mid_rst_irq");
    wr0(ADDR_SNAPL, 16'h0000);
    rd0(ADDR_SNAPL,   16'h61A7, "mid_rst_count");
    rd1(ADDR_PERIODL, 16'h61A7, "w15_mid_rst_periodl");

    idle(3);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
